// File: rtl/multiplicador_secuencial.sv
// Sequential shift-add multiplier, one multiplier bit per clock, with a start/ready handshake.
// Optional macro MULT_SIGNO_EN adds a 'signo' input that selects two's complement operands.
module multiplicador_secuencial #(
  parameter  int ANCHO     = 8,
  localparam int ANCHO_CNT = $clog2(ANCHO + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 inicio,
`ifdef MULT_SIGNO_EN
  input  logic                 signo,
`endif
  input  logic [ANCHO-1:0]     a,
  input  logic [ANCHO-1:0]     b,
  output logic                 listo,
  output logic [2*ANCHO-1:0]   producto,
  output logic                 valido,
  output logic                 ocupado,
  output logic [1:0]           estado
);

  // Handshake: an operation is accepted on a rising edge where inicio && listo.
  // listo is high only in REPOSO; valido pulses for the single FIN cycle in which
  // producto carries the new result. inicio while listo=0 is dropped, not queued.

  typedef enum logic [1:0] {
    REPOSO  = 2'd0,
    CALCULO = 2'd1,
    FIN     = 2'd2
  } estado_t;

  localparam logic [ANCHO_CNT-1:0] CNT_FIN = ANCHO_CNT'(ANCHO);
  localparam logic [ANCHO_CNT-1:0] CNT_UNO = ANCHO_CNT'(1);

  estado_t                estado_q, estado_d;
  logic [2*ANCHO-1:0]     multiplicando;
  logic [ANCHO-1:0]       multiplicador;
  logic [2*ANCHO-1:0]     acumulador;
  logic [ANCHO_CNT-1:0]   contador;
  logic                   negativo;

  logic [ANCHO-1:0]       mag_a;
  logic [ANCHO-1:0]       mag_b;
  logic                   neg_in;

`ifdef MULT_SIGNO_EN
  // Magnitudes fit in ANCHO bits even for the most negative value (it reads back as 2^(ANCHO-1)).
  always_comb begin
    mag_a  = (signo && a[ANCHO-1]) ? -a : a;
    mag_b  = (signo && b[ANCHO-1]) ? -b : b;
    neg_in = signo && (a[ANCHO-1] ^ b[ANCHO-1]);
  end
`else
  assign mag_a  = a;
  assign mag_b  = b;
  assign neg_in = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) estado_q <= REPOSO;
    else       estado_q <= estado_d;
  end

  always_comb begin
    estado_d = estado_q;
    listo    = 1'b0;
    valido   = 1'b0;
    ocupado  = 1'b1;
    case (estado_q)
      REPOSO: begin
        listo   = 1'b1;
        ocupado = 1'b0;
        if (inicio) estado_d = CALCULO;
      end
      CALCULO: begin
        if (contador == CNT_FIN) estado_d = FIN;
      end
      FIN: begin
        valido   = 1'b1;
        estado_d = REPOSO;
      end
      default: estado_d = REPOSO;
    endcase
  end

  assign estado = estado_q;

  // Datapath: ANCHO iterations, then one extra CALCULO edge that commits the result.
  always_ff @(posedge clk) begin
    if (reset) begin
      multiplicando <= '0;
      multiplicador <= '0;
      acumulador    <= '0;
      contador      <= '0;
      negativo      <= 1'b0;
      producto      <= '0;
    end else begin
      case (estado_q)
        REPOSO: begin
          if (inicio) begin
            multiplicando <= {{ANCHO{1'b0}}, mag_a};
            multiplicador <= mag_b;
            acumulador    <= '0;
            contador      <= '0;
            negativo      <= neg_in;
          end
        end
        CALCULO: begin
          if (contador != CNT_FIN) begin
            if (multiplicador[0]) acumulador <= acumulador + multiplicando;
            multiplicando <= multiplicando << 1;
            multiplicador <= multiplicador >> 1;
            contador      <= contador + CNT_UNO;
          end else begin
            producto <= negativo ? -acumulador : acumulador;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multiplicador_secuencial.sv
// Bench for multiplicador_secuencial (ANCHO=8): scoreboard of expected products and acceptance edges,
// checked by a monitor whenever valido pulses. Signed cases run when MULT_SIGNO_EN is defined.
module tb_multiplicador_secuencial;
  localparam int ANCHO = 8;
  localparam int W     = 2 * ANCHO;
  localparam int LAT   = ANCHO + 1;
  localparam int PERIODO = ANCHO + 3;

  logic             clk = 1'b0;
  logic             reset;
  logic             inicio;
  logic             signo;
  logic [ANCHO-1:0] a, b;
  logic             listo, valido, ocupado;
  logic [W-1:0]     producto;
  logic [1:0]       estado;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [W-1:0] exp_q[$];
  int           lat_q[$];

  multiplicador_secuencial #(.ANCHO(ANCHO)) dut (
    .clk      (clk),
    .reset    (reset),
    .inicio   (inicio),
`ifdef MULT_SIGNO_EN
    .signo    (signo),
`endif
    .a        (a),
    .b        (b),
    .listo    (listo),
    .producto (producto),
    .valido   (valido),
    .ocupado  (ocupado),
    .estado   (estado)
  );

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic logic [W-1:0] modelo(input logic [ANCHO-1:0] ma, input logic [ANCHO-1:0] mb,
                                          input logic ms);
    logic signed [W-1:0] sa, sb;
    if (ms) begin
      sa = {{ANCHO{ma[ANCHO-1]}}, ma};
      sb = {{ANCHO{mb[ANCHO-1]}}, mb};
      return W'(sa * sb);
    end
    return W'({{ANCHO{1'b0}}, ma} * {{ANCHO{1'b0}}, mb});
  endfunction

  // scoreboard monitor
  always @(negedge clk) begin
    logic [W-1:0] e;
    int l;
    if (valido === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_valido cyc=%0d producto=0x%0h", cyc, producto);
      end else begin
        e = exp_q.pop_front();
        l = lat_q.pop_front();
        total++;
        if (producto !== e) begin
          bad++;
          $display("FAIL producto got=0x%0h exp=0x%0h", producto, e);
        end
        total++;
        if (cyc - l !== LAT) begin
          bad++;
          $display("FAIL latency got=%0d exp=%0d", cyc - l, LAT);
        end
      end
    end
  end

  // driver tasks (start and end at a falling edge)
  task automatic drive_op(input logic [ANCHO-1:0] ta, input logic [ANCHO-1:0] tb_v, input logic ts,
                          input bit push);
    int n = 0;
    while (listo !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) begin
      total++; bad++;
      $display("FAIL listo_timeout got=%b exp=1", listo);
    end
    a = ta; b = tb_v; signo = ts; inicio = 1'b1;
    if (push) begin
      exp_q.push_back(modelo(ta, tb_v, ts));
      lat_q.push_back(cyc + 1);
    end
    @(negedge clk);
    inicio = 1'b0;
    total++;
    if (listo !== 1'b0 || ocupado !== 1'b1) begin
      bad++;
      $display("FAIL accept listo=%b ocupado=%b exp listo=0 ocupado=1", listo, ocupado);
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((exp_q.size() != 0 || listo !== 1'b1) && n < 200) begin @(negedge clk); n++; end
    if (n >= 200) begin
      total++; bad++;
      $display("FAIL result_timeout pending=%0d exp=0", exp_q.size());
      exp_q.delete(); lat_q.delete();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; inicio = 1'b0; signo = 1'b0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      total++;
      if (producto !== '0 || valido !== 1'b0 || listo !== 1'b1 || ocupado !== 1'b0) begin
        bad++;
        $display("FAIL reset_idle producto=0x%0h valido=%b listo=%b ocupado=%b exp 0/0/1/0",
                 producto, valido, listo, ocupado);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_basic();
    drive_op(8'd13, 8'd11, 1'b0, 1'b1);
    wait_idle();
    for (int i = 0; i < 5; i++) begin
      total++;
      if (producto !== 16'd143) begin
        bad++;
        $display("FAIL hold got=0x%0h exp=0x008f", producto);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_corners();
    drive_op(8'd255, 8'd255, 1'b0, 1'b1);
    drive_op(8'd0,   8'd200, 1'b0, 1'b1);
    drive_op(8'd1,   8'd1,   1'b0, 1'b1);
    for (int i = 0; i < 6; i++)
      drive_op(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'b0, 1'b1);
    wait_idle();
  endtask

  task automatic test_back_to_back();
    int next_acc = cyc + 1;
    inicio = 1'b1; signo = 1'b0;
    for (int i = 0; i < 3 * PERIODO; i++) begin
      a = 8'($urandom_range(0, 255));
      b = 8'($urandom_range(0, 255));
      if (cyc + 1 == next_acc) begin
        exp_q.push_back(modelo(a, b, 1'b0));
        lat_q.push_back(next_acc);
        next_acc += PERIODO;
      end
      @(negedge clk);
    end
    inicio = 1'b0;
    wait_idle();
  endtask

  task automatic test_reset_mid();
    drive_op(8'd7, 8'd9, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    total++;
    if (producto !== '0 || listo !== 1'b1 || valido !== 1'b0 || ocupado !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid producto=0x%0h listo=%b valido=%b ocupado=%b exp 0/1/0/0",
               producto, listo, valido, ocupado);
    end
    repeat (15) @(negedge clk);
    drive_op(8'd7, 8'd9, 1'b0, 1'b1);
    wait_idle();
    total++;
    if (producto !== 16'd63) begin
      bad++;
      $display("FAIL after_reset got=%0d exp=63", producto);
    end
  endtask

  task automatic test_reset_with_inicio();
    a = 8'd3; b = 8'd3; inicio = 1'b1; reset = 1'b1;
    @(negedge clk);
    inicio = 1'b0; reset = 1'b0;
    total++;
    if (listo !== 1'b1 || ocupado !== 1'b0 || producto !== '0) begin
      bad++;
      $display("FAIL reset_wins listo=%b ocupado=%b producto=0x%0h exp 1/0/0", listo, ocupado, producto);
    end
    repeat (15) @(negedge clk);
  endtask

`ifdef MULT_SIGNO_EN
  task automatic test_signo();
    drive_op(8'hFD, 8'd5,  1'b1, 1'b1);
    drive_op(8'h80, 8'h80, 1'b1, 1'b1);
    drive_op(8'hFD, 8'd5,  1'b0, 1'b1);
    drive_op(8'h80, 8'h7F, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++)
      drive_op(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'b1, 1'b1);
    wait_idle();
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_corners();
    test_back_to_back();
    test_reset_mid();
    test_reset_with_inicio();
`ifdef MULT_SIGNO_EN
    test_signo();
`endif
    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
